// File: rtl/fp_radial_accum_pkg.sv
// Fixed-point definitions shared by the fingerprint datapath and the
// radial-accumulator constants.
`ifndef FIXED_PKG_VH
`define FIXED_PKG_VH
`define QWIDTH 32
`define Q 16
`define QONE 32'h0001_0000
`define QMAX 32'h7FFF_FFFF
`define QZERO 32'h0000_0000
`define FP_CNT_W 8
`endif

package fp_radial_accum_pkg;

   localparam int QW       = `QWIDTH;
   localparam int QF       = `Q;
   localparam int MUL_W    = 48;
   localparam int FP_CNT_W = `FP_CNT_W;

   localparam logic [QW-1:0] QMAX = `QMAX;

   localparam logic [1:0] ST_ACC   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_OUT   = 2'd2;

endpackage

// File: rtl/fp_radial_accum_qmul.sv
// fp_qmul_clamp: combinational Q16.16 multiply; negative operands count as
// zero, result is (a*b)>>>Q as a 48-bit unsigned value.
module fp_qmul_clamp
   import fp_radial_accum_pkg::*;
(
   input  logic [QW-1:0]    op_a,
   input  logic [QW-1:0]    op_b,
   output logic [MUL_W-1:0] prod
);

   logic [QW-1:0]   a_c_s;
   logic [QW-1:0]   b_c_s;
   logic [2*QW-1:0] full_s;
   logic            unused_lsb_s;

   assign a_c_s  = op_a[QW-1] ? {QW{1'b0}} : op_a;
   assign b_c_s  = op_b[QW-1] ? {QW{1'b0}} : op_b;
   assign full_s = {{QW{1'b0}}, a_c_s} * {{QW{1'b0}}, b_c_s};

   // Both operands are non-negative, so the shift-right is the floor.
   assign prod         = full_s[QF+MUL_W-1:QF];
   assign unused_lsb_s = ^full_s[QF-1:0];

endmodule

// File: rtl/fp_radial_accum.sv
// Radial fingerprint accumulator: sums exp*fc over one neighbour frame.
// Optional FP_ACC_SAT_EN: saturating accumulator and clamped out_g/out_ovf.
module fp_radial_accum
   import fp_radial_accum_pkg::*;
#(
   parameter int ACC_W = 48,
   parameter int CNT_W = FP_CNT_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [QW-1:0]    in_exp,
   input  logic [QW-1:0]    in_fc,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [QW-1:0]    out_g,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic             accept_s;
   logic             consume_s;
   logic [MUL_W-1:0] q_s;
   logic [ACC_W-1:0] p_r;
   logic             p_valid_r;
   logic             p_last_r;
   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] acc_sum_s;
   logic [CNT_W-1:0] cnt_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [QW-1:0]    out_g_r;
   logic [CNT_W-1:0] out_cnt_r;
   logic             out_ovf_r;
   logic [QW-1:0]    g_nxt_s;
   logic             ovf_nxt_s;

   assign accept_s  = in_valid & in_ready_r & (state_r == ST_ACC);
   assign consume_s = out_valid_r & out_ready & (state_r == ST_OUT);

   fp_qmul_clamp u_qmul (
      .op_a (in_exp),
      .op_b (in_fc),
      .prod (q_s)
   );

`ifdef FP_ACC_SAT_EN
   localparam logic [ACC_W-1:0] ACC_QMAX = ACC_W'(QMAX);
   logic [ACC_W:0] wide_sum_s;

   assign wide_sum_s = {1'b0, acc_r} + {1'b0, p_r};

   // Saturating add and output clamp.
   always_comb begin
      acc_sum_s = wide_sum_s[ACC_W-1:0];
      g_nxt_s   = acc_r[QW-1:0];
      ovf_nxt_s = 1'b0;
      if (wide_sum_s > {2'b00, {(ACC_W-1){1'b1}}}) begin
         acc_sum_s = {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         acc_sum_s = wide_sum_s[ACC_W-1:0];
      end
      if (acc_r > ACC_QMAX) begin
         g_nxt_s   = QMAX;
         ovf_nxt_s = 1'b1;
      end else begin
         g_nxt_s   = acc_r[QW-1:0];
         ovf_nxt_s = 1'b0;
      end
   end
`else
   logic unused_acc_hi_s;

   assign acc_sum_s       = acc_r + p_r;
   assign g_nxt_s         = acc_r[QW-1:0];
   assign ovf_nxt_s       = 1'b0;
   assign unused_acc_hi_s = ^acc_r[ACC_W-1:QW];
`endif

   // Frame sequencing: collect beats, drain the product stage, present result.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_ACC: begin
            if (accept_s && in_last) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_ACC;
            end
         end
         ST_FLUSH: begin
            if (p_valid_r && p_last_r) begin
               state_nxt_s = ST_OUT;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         ST_OUT: begin
            if (consume_s) begin
               state_nxt_s = ST_ACC;
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         default: state_nxt_s = ST_ACC;
      endcase
   end

   // State register; in_ready is registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_ACC;
         in_ready_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         in_ready_r <= (state_nxt_s == ST_ACC);
      end
   end

   // Stage 1: registered clamped product of the accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_r       <= {ACC_W{1'b0}};
         p_valid_r <= 1'b0;
         p_last_r  <= 1'b0;
      end else if (accept_s) begin
         p_r       <= ACC_W'(q_s);
         p_valid_r <= 1'b1;
         p_last_r  <= in_last;
      end else begin
         p_valid_r <= 1'b0;
         p_last_r  <= 1'b0;
      end
   end

   // Stage 2: accumulate products and count beats; cleared when the result leaves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else if (consume_s) begin
         acc_r <= {ACC_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (p_valid_r) begin
            acc_r <= acc_sum_s;
         end
         if (accept_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Result register: loaded once acc is final, held until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_g_r     <= {QW{1'b0}};
         out_cnt_r   <= {CNT_W{1'b0}};
         out_ovf_r   <= 1'b0;
      end else if ((state_r == ST_OUT) && !out_valid_r) begin
         out_valid_r <= 1'b1;
         out_g_r     <= g_nxt_s;
         out_cnt_r   <= cnt_r;
         out_ovf_r   <= ovf_nxt_s;
      end else if (consume_s) begin
         out_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_g     = out_g_r;
   assign out_cnt   = out_cnt_r;
   assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_fp_radial_accum.sv
// Directed, table-driven bench for fp_radial_accum (default CNT_W=8).
module tb_fp_radial_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_exp;
   logic [31:0] in_fc;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_g;
   logic [7:0]  out_cnt;
   logic        out_ovf;

   int n_vec = 0;
   int n_mis = 0;

   typedef struct {
      logic [31:0] exp_v;
      logic [31:0] fc_v;
      logic        last;
      logic [31:0] g_exp;
      logic [7:0]  cnt_exp;
   } vec_t;

   vec_t vecs [0:9];

   fp_radial_accum dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_exp    (in_exp),
      .in_fc     (in_fc),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_g     (out_g),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic drive_beat(input logic [31:0] e, input logic [31:0] f, input logic l);
      int waited;
      in_exp   = e;
      in_fc    = f;
      in_last  = l;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_vec++;
         n_mis++;
         $display("FAIL beat_accept: in_ready stuck at %b, required 1", in_ready);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   // Called at the negedge right after the last beat was accepted.
   task automatic get_result(input string name, input logic [31:0] g_e, input logic [7:0] c_e,
                             input logic ovf_e, input int hold);
      int cycles;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      if (!out_valid) begin
         n_vec++;
         n_mis++;
         $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, cycles);
      end else begin
         check({name, "_lat"}, 64'(cycles), 64'd2);
         check({name, "_g"}, 64'(out_g), 64'(g_e));
         check({name, "_cnt"}, 64'(out_cnt), 64'(c_e));
         check({name, "_ovf"}, 64'(out_ovf), 64'(ovf_e));
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_v"}, 64'(out_valid), 64'd1);
            check({name, "_hold_g"}, 64'(out_g), 64'(g_e));
            check({name, "_hold_cnt"}, 64'(out_cnt), 64'(c_e));
            check({name, "_hold_rdy"}, 64'(in_ready), 64'd0);
         end
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready = 1'b0;
         check({name, "_done_v"}, 64'(out_valid), 64'd0);
         check({name, "_done_rdy"}, 64'(in_ready), 64'd1);
      end
   endtask

   initial begin
      vecs[0] = '{32'h0001_0000, 32'h0000_8000, 1'b0, 32'h0, 8'd0};
      vecs[1] = '{32'h0001_0000, 32'h0000_8000, 1'b0, 32'h0, 8'd0};
      vecs[2] = '{32'h0001_0000, 32'h0000_8000, 1'b1, 32'h0001_8000, 8'd3};
      vecs[3] = '{32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0, 8'd0};
      vecs[4] = '{32'h0000_4000, 32'h0001_0000, 1'b1, 32'h0000_4000, 8'd2};
      vecs[5] = '{32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 8'd1};
      vecs[6] = '{32'h0002_0000, 32'h0001_8000, 1'b0, 32'h0, 8'd0};
      vecs[7] = '{32'h0000_8000, 32'hFFFF_8000, 1'b1, 32'h0003_0000, 8'd2};
      vecs[8] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0, 8'd0};
      vecs[9] = '{32'h0001_0001, 32'h0001_0001, 1'b1, 32'h0001_0002, 8'd2};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_exp    = 32'h0;
      in_fc     = 32'h0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_g", 64'(out_g), 64'd0);
      check("rst_out_cnt", 64'(out_cnt), 64'd0);
      check("rst_out_ovf", 64'(out_ovf), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 10; i++) begin
         drive_beat(vecs[i].exp_v, vecs[i].fc_v, vecs[i].last);
         if (vecs[i].last) begin
            get_result($sformatf("vec%0d", i), vecs[i].g_exp, vecs[i].cnt_exp, 1'b0, 0);
         end
      end

      // Bubbles mid-frame, out_ready high outside OUT, then backpressure.
      out_ready = 1'b1;
      drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0);
      @(negedge clk);
      drive_beat(32'h0002_0000, 32'h0000_8000, 1'b0);
      repeat (2) @(negedge clk);
      drive_beat(32'h0000_8000, 32'h0001_0000, 1'b1);
      out_ready = 1'b0;
      get_result("bp", 32'h0002_8000, 8'd3, 1'b0, 5);
      drive_beat(32'h0000_2000, 32'h0001_0000, 1'b1);
      get_result("bp_next", 32'h0000_2000, 8'd1, 1'b0, 0);

      // Overflow of the 32-bit output: exact sum is 0x13_FFD8_0000.
      for (int i = 0; i < 40; i++) begin
         drive_beat(32'h7FFF_0000, 32'h0001_0000, (i == 39));
      end
`ifdef FP_ACC_SAT_EN
      get_result("ovf", 32'h7FFF_FFFF, 8'd40, 1'b1, 0);
`else
      get_result("ovf", 32'hFFD8_0000, 8'd40, 1'b0, 0);
`endif

      // Reset in the middle of a frame discards the partial sum.
      drive_beat(32'h0003_0000, 32'h0001_0000, 1'b0);
      drive_beat(32'h0003_0000, 32'h0001_0000, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mrst_in_ready", 64'(in_ready), 64'd0);
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_out_g", 64'(out_g), 64'd0);
      check("mrst_out_cnt", 64'(out_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_rel_rdy", 64'(in_ready), 64'd1);
      drive_beat(32'h0001_0000, 32'h0001_0000, 1'b1);
      get_result("mrst_frame", 32'h0001_0000, 8'd1, 1'b0, 0);

      // Neighbour count saturates at 255.
      for (int i = 0; i < 300; i++) begin
         drive_beat(32'h0001_0000, 32'h0000_0000, (i == 299));
      end
      get_result("cntsat", 32'h0000_0000, 8'd255, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
